// File: rtl/jtframe_rom_rrarb_pkg.sv
// Shared definitions for the round-robin SDRAM ROM arbiter: FSM encoding and address helpers.
package jtframe_rom_rrarb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // SDRAM 16-bit word address of a slot access; caller zero-extends and truncates.
  function automatic logic [31:0] word_addr(input logic [31:0] offset,
                                            input logic [31:0] addr,
                                            input logic        dw32);
    logic [31:0] w;
    w = dw32 ? {addr[30:0], 1'b0} : {1'b0, addr[31:2], 1'b0};
    return offset + w;
  endfunction

  // Little-endian byte lane select.
  function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] s);
    return d[{s, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/jtframe_rom_line.sv
// One-line 32-bit ROM cache for a single arbiter slot: valid, tag, data, hit and byte select.
module jtframe_rom_line
  import jtframe_rom_rrarb_pkg::*;
#(
  parameter int unsigned AW   = 18,
  parameter bit          DW32 = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_we,
  input  logic          i_cs,
  input  logic [AW-1:0] i_addr,
  input  logic [AW-1:0] i_tag,
  input  logic [31:0]   i_data,
  output logic [AW-1:0] o_tag,
  output logic          o_hit,
  output logic [31:0]   o_dout
);

  logic          r_valid;
  logic [AW-1:0] r_tag;
  logic [31:0]   r_data;

  // Narrow slots tag on the 32-bit word; the two low bits pick the byte.
  assign o_tag  = DW32 ? i_addr : {2'b00, i_addr[AW-1:2]};
  assign o_hit  = i_cs & r_valid & (r_tag == o_tag);
  assign o_dout = DW32 ? r_data : {24'd0, byte_sel(r_data, i_addr[1:0])};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_we) begin
      r_valid <= 1'b1;
      r_tag   <= i_tag;
      r_data  <= i_data;
    end
  end

endmodule

// File: rtl/jtframe_rom_rrarb.sv
// Round-robin SDRAM ROM arbiter: per-slot one-line caches sharing a single SDRAM read port.
module jtframe_rom_rrarb
  import jtframe_rom_rrarb_pkg::*;
#(
  parameter int unsigned            SLOTS   = 5,
  parameter int unsigned            AW      = 18,
  parameter int unsigned            SDAW    = 22,
  parameter logic [SLOTS*SDAW-1:0]  OFFSETS = '0,
  parameter logic [SLOTS-1:0]       DW32    = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_downloading,
  input  logic                  i_loop_rst,
  input  logic [SLOTS-1:0]      i_slot_cs,
  input  logic [SLOTS*AW-1:0]   i_slot_addr,
  output logic [SLOTS-1:0]      o_slot_ok,
  output logic [SLOTS*32-1:0]   o_slot_dout,
  output logic                  o_sdram_req,
  input  logic                  i_sdram_ack,
  input  logic                  i_data_rdy,
  output logic [SDAW-1:0]       o_sdram_addr,
  input  logic [31:0]           i_data_read,
  output logic                  o_refresh_en
);

  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic                 w_flush;
  logic [SLOTS-1:0]     w_hit;
  logic [SLOTS-1:0]     w_miss;
  logic [SLOTS-1:0]     w_we;
  logic [AW-1:0]        w_tag   [SLOTS];
  logic [SDAW-1:0]      w_waddr [SLOTS];
  logic                 w_found;
  logic [IW-1:0]        w_pick;

  logic [1:0]           r_state;
  logic [IW-1:0]        r_rr;
  logic [IW-1:0]        r_gnt;
  logic [AW-1:0]        r_tag;
  logic                 r_req;
  logic [SDAW-1:0]      r_addr;

  assign w_flush = i_downloading | i_loop_rst;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign w_we[gi] = (r_state == ST_WAIT) & i_data_rdy & ~w_flush & (r_gnt == IW'(gi));
    assign w_waddr[gi] = SDAW'(word_addr({{(32-SDAW){1'b0}}, OFFSETS[gi*SDAW +: SDAW]},
                                         {{(32-AW){1'b0}}, i_slot_addr[gi*AW +: AW]},
                                         DW32[gi]));

    jtframe_rom_line #(
      .AW   (AW),
      .DW32 (DW32[gi])
    ) u_line (
      .clk    (clk),
      .rst    (rst),
      .i_flush(w_flush),
      .i_we   (w_we[gi]),
      .i_cs   (i_slot_cs[gi]),
      .i_addr (i_slot_addr[gi*AW +: AW]),
      .i_tag  (r_tag),
      .i_data (i_data_read),
      .o_tag  (w_tag[gi]),
      .o_hit  (w_hit[gi]),
      .o_dout (o_slot_dout[gi*32 +: 32])
    );
  end

  assign w_miss       = i_slot_cs & ~w_hit;
  // Lines clear one cycle after the flush request, so mask ok during it as well.
  assign o_slot_ok    = w_hit & {SLOTS{~w_flush}};
  assign o_refresh_en = (r_state == ST_IDLE) & ~|w_miss;
  assign o_sdram_req  = r_req;
  assign o_sdram_addr = r_addr;

  // First missing slot after the last grant, wrapping modulo SLOTS.
  always_comb begin
    logic [IW:0] idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = '0;
    for (int unsigned k = 1; k <= SLOTS; k++) begin
      idx = {1'b0, r_rr} + (IW+1)'(k);
      if (idx >= (IW+1)'(SLOTS)) idx = idx - (IW+1)'(SLOTS);
      if (!w_found && w_miss[idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rr    <= IW'(SLOTS - 1);
      r_gnt   <= '0;
      r_tag   <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
    end else if (w_flush) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_gnt   <= w_pick;
            r_rr    <= w_pick;
            r_tag   <= w_tag[w_pick];
            r_addr  <= w_waddr[w_pick];
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_sdram_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_data_rdy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jtframe_rom_rrarb.sv
// Scoreboard bench for jtframe_rom_rrarb: expected SDRAM addresses are queued with stimulus
// and popped by a small SDRAM responder as requests appear.
module tb_jtframe_rom_rrarb;

  localparam int unsigned SLOTS = 5;
  localparam int unsigned AW    = 18;
  localparam int unsigned SDAW  = 22;
  localparam logic [SLOTS*SDAW-1:0] OFFSETS = {22'h20000, 22'h0, 22'h100, 22'h0, 22'h0};
  localparam logic [SLOTS-1:0]      DW32    = 5'b10000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  downloading;
  logic                  loop_rst;
  logic [SLOTS-1:0]      slot_cs;
  logic [SLOTS*AW-1:0]   slot_addr;
  logic [SLOTS-1:0]      slot_ok;
  logic [SLOTS*32-1:0]   slot_dout;
  logic                  sdram_req;
  logic                  sdram_ack;
  logic                  data_rdy;
  logic [SDAW-1:0]       sdram_addr;
  logic [31:0]           data_read;
  logic                  refresh_en;

  logic [AW-1:0]         addr_v [SLOTS];
  logic [SDAW-1:0]       exp_q [$];
  int                    n_checks = 0;
  int                    n_fail   = 0;
  int                    n_grants = 0;

  always #5 clk = ~clk;

  always_comb begin
    slot_addr = '0;
    for (int i = 0; i < SLOTS; i++) slot_addr[i*AW +: AW] = addr_v[i];
  end

  jtframe_rom_rrarb #(
    .SLOTS  (SLOTS),
    .AW     (AW),
    .SDAW   (SDAW),
    .OFFSETS(OFFSETS),
    .DW32   (DW32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_downloading(downloading),
    .i_loop_rst   (loop_rst),
    .i_slot_cs    (slot_cs),
    .i_slot_addr  (slot_addr),
    .o_slot_ok    (slot_ok),
    .o_slot_dout  (slot_dout),
    .o_sdram_req  (sdram_req),
    .i_sdram_ack  (sdram_ack),
    .i_data_rdy   (data_rdy),
    .o_sdram_addr (sdram_addr),
    .i_data_read  (data_read),
    .o_refresh_en (refresh_en)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem(input logic [SDAW-1:0] a);
    return (a == 22'h8) ? 32'hDDCCBBAA : {a[7:0], 2'b00, a};
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] s);
    return 8'((w >> (8 * s)) & 32'hFF);
  endfunction

  // SDRAM model: ack one cycle after req, data two cycles after ack.
  initial begin
    logic [SDAW-1:0] a;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = '0;
    forever begin
      @(posedge clk); #1;
      if (sdram_req) begin
        a = sdram_addr;
        n_grants++;
        check("req_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("req_addr", 64'(a), 64'(exp_q.pop_front()));
        sdram_ack = 1'b1;
        @(posedge clk); #1;
        sdram_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        data_read = mem(a);
        data_rdy  = 1'b1;
        @(posedge clk); #1;
        data_rdy  = 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst         = 1'b1;
    downloading = 1'b0;
    loop_rst    = 1'b0;
    slot_cs     = '0;
    for (int i = 0; i < SLOTS; i++) addr_v[i] = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ok(input string tag, input logic [SLOTS-1:0] mask);
    int t = 0;
    @(negedge clk);
    while (((slot_ok & mask) !== mask) && t < 60) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(slot_ok & mask), 64'(mask));
  endtask

  task automatic wait_req(input string tag);
    int t = 0;
    @(negedge clk);
    while (!sdram_req && t < 60) begin
      @(negedge clk);
      t++;
    end
    check(tag, 64'(sdram_req), 64'd1);
  endtask

  initial begin
    int g;
    do_reset();
    check("rst_req", 64'(sdram_req), 64'd0);
    check("rst_addr", 64'(sdram_addr), 64'd0);
    check("rst_refresh", 64'(refresh_en), 64'd1);
    check("rst_ok", 64'(slot_ok), 64'd0);
    check("rst_dout", 64'(|slot_dout), 64'd0);
    tick();
    rst = 1'b0;

    // Single 8-bit miss and byte select
    tick();
    slot_cs[0] = 1'b1;
    addr_v[0]  = 18'h10;
    exp_q.push_back(22'h8);
    @(negedge clk);
    check("miss_refresh", 64'(refresh_en), 64'd0);
    wait_ok("t1_ok", 5'b00001);
    check("t1_dout", 64'(slot_dout[31:0]), 64'hAA);
    g = n_grants;
    for (int b = 1; b < 4; b++) begin
      tick();
      addr_v[0] = 18'h10 + 18'(b);
      @(negedge clk);
      check("bytesel_ok", 64'(slot_ok[0]), 64'd1);
      check("bytesel_dout", 64'(slot_dout[31:0]), 64'(byte_of(32'hDDCCBBAA, 2'(b))));
    end
    check("no_refetch", 64'(n_grants), 64'(g));
    check("hit_refresh", 64'(refresh_en), 64'd1);

    // Round-robin from reset, including the 32-bit slot with offset
    do_reset();
    tick();
    rst = 1'b0;
    tick();
    slot_cs   = 5'b10101;
    addr_v[0] = 18'h20;
    addr_v[2] = 18'h30;
    addr_v[4] = 18'h123;
    exp_q.push_back(22'h10);
    exp_q.push_back(22'h118);
    exp_q.push_back(22'h20246);
    wait_ok("rr1_ok", 5'b10101);
    check("rr1_drained", 64'(exp_q.size()), 64'd0);
    check("dw32_dout", 64'(slot_dout[4*32 +: 32]), 64'(mem(22'h20246)));
    check("rr1_refresh", 64'(refresh_en), 64'd1);
    tick();
    addr_v[0] = 18'h40;
    addr_v[2] = 18'h50;
    addr_v[4] = 18'h200;
    exp_q.push_back(22'h20);
    exp_q.push_back(22'h128);
    exp_q.push_back(22'h20400);
    wait_ok("rr2_ok", 5'b10101);
    check("rr2_drained", 64'(exp_q.size()), 64'd0);
    check("rr2_dout2", 64'(slot_dout[2*32 +: 32]), 64'(byte_of(mem(22'h128), 2'b00)));

    // loop_rst flush
    tick();
    slot_cs   = 5'b00010;
    addr_v[1] = 18'h8;
    exp_q.push_back(22'h4);
    wait_ok("f1_ok", 5'b00010);
    tick();
    loop_rst = 1'b1;
    @(negedge clk);
    check("flush_ok", 64'(slot_ok), 64'd0);
    tick();
    loop_rst = 1'b0;
    exp_q.push_back(22'h4);
    @(negedge clk);
    check("flush_invalid", 64'(slot_ok[1]), 64'd0);
    wait_ok("f2_ok", 5'b00010);

    // downloading during WAIT: in-flight data must be dropped
    tick();
    addr_v[1] = 18'hC;
    exp_q.push_back(22'h6);
    wait_req("dl_req");
    tick();
    downloading = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("dl_ok", 64'(slot_ok[1]), 64'd0);
      check("dl_req_low", 64'(sdram_req), 64'd0);
      tick();
    end
    downloading = 1'b0;
    exp_q.push_back(22'h6);
    @(negedge clk);
    check("dl_still_invalid", 64'(slot_ok[1]), 64'd0);
    wait_ok("dl2_ok", 5'b00010);
    check("dl2_dout", 64'(slot_dout[1*32 +: 32]), 64'h06);

    // Address change while waiting for data
    g = n_grants;
    tick();
    addr_v[1] = 18'h40;
    exp_q.push_back(22'h20);
    wait_req("ac_req");
    tick();
    addr_v[1] = 18'h80;
    exp_q.push_back(22'h40);
    @(negedge clk);
    check("ac_refresh", 64'(refresh_en), 64'd0);
    wait_ok("ac_ok", 5'b00010);
    check("ac_grants", 64'(n_grants - g), 64'd2);
    check("ac_dout", 64'(slot_dout[1*32 +: 32]), 64'(byte_of(mem(22'h40), 2'b00)));
    check("ac_refresh_end", 64'(refresh_en), 64'd1);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
